tinyqv_divider: RTL
===================

// Module: tinyqv_divider
// PURPOSE
//  Multi-cycle integer divide unit for the RV32M DIV/DIVU/REM/REMU group; the inverse-arithmetic companion to the single-cycle ALU/shifter.
//  The core launches an operation with a start pulse. It stalls on busy and captures d when done pulses.
//  Restoring shift-subtract on operand magnitudes, with sign fix-up in a final cycle.
// PARAMETERS
//  BITS_PER_CYCLE  1  quotient bits resolved per clock; legal values 1 or 2; N_ITER = 32/BITS_PER_CYCLE
// PORTS
//  clk     in   1   core clock, rising edge
//  rstn    in   1   asynchronous active-low reset
//  start   in   1   launch request; sampled only while busy=0
//  op      in   2   00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]); sampled with start
//  a       in   32  dividend; sampled with start
//  b       in   32  divisor; sampled with start
//  cancel  in   1   flush (branch/interrupt); abandons any operation in flight
//  busy    out  1   operation in progress
//  done    out  1   one-cycle pulse: d is valid
//  d       out  32  quotient (op[1]=0) or remainder (op[1]=1); held until the next done
// BEHAVIOUR
//  Reset (rstn=0, async): state=IDLE; busy=0, done=0, d=0; all internal regs cleared. Reset mid-operation discards it with no done pulse.
//  States: IDLE -> RUN (N_ITER cycles) -> FIX (1 cycle) -> IDLE.
//  IDLE: on the edge with start=1 and cancel=0:
//   - latch op.
//   - signed = ~op[0]; latch |a| and |b| as 32-bit unsigned magnitudes (|-2^31| = 0x80000000).
//   - latch neg_q = signed & (a[31]^b[31]) & (b!=0); latch neg_r = signed & a[31].
//   - latch div0 = (b==0); clear the remainder accumulator; busy=1 from this edge.
//  RUN: each edge shifts BITS_PER_CYCLE dividend bits MSB-first into a 33-bit partial remainder.
//   - each step: trial subtract the divisor magnitude; if no borrow, keep the difference and set the quotient bit to 1, else restore and set it to 0.
//   - an iteration counter runs 0..N_ITER-1; the last iteration moves to FIX.
//  FIX edge: d <= the selected result, then sign-corrected:
//   - quotient negated if neg_q; remainder negated if neg_r.
//   - done=1 for exactly one cycle after this edge; busy=0 on the same edge.
//  Latency: start at edge k -> done high after edge k+N_ITER+1 (33 cycles at BITS_PER_CYCLE=1, 17 at 2). Latency is fixed; no early exit.
//  Divide by zero (div0): quotient = 0xFFFFFFFF for DIV and DIVU; remainder = a unmodified for REM and REMU.
//   - Forced at FIX; no trap, same latency.
//  Overflow (DIV/REM of 0x80000000 by 0xFFFFFFFF): quotient 0x80000000, remainder 0. Falls out of the magnitude path; no special case.
//  start while busy=1: ignored, not queued.
//  start asserted on the done cycle: accepted (busy=0), so back-to-back operations are allowed.
//  cancel=1: state -> IDLE on the next edge; busy=0; no done pulse; d keeps its previous value.
//   - cancel and start on the same IDLE edge: cancel wins, nothing is launched.
//  Arithmetic: all magnitudes unsigned 32-bit; the trial subtract is 33-bit, borrow = bit 32.
//   - sign fix uses two's complement (~x+1), truncated to 32 bits.
// TESTING
//  DIVU a=100, b=7 -> done 33 cycles after start (BITS_PER_CYCLE=1), d=14; REMU -> d=2.
//  DIV a=-7 (0xFFFFFFF9), b=2 -> d=0xFFFFFFFD (-3); REM -> d=0xFFFFFFFF (-1, sign of dividend).
//  DIV/REM a=0x80000000, b=0xFFFFFFFF -> d=0x80000000 / d=0; DIVU a=5, b=0 -> 0xFFFFFFFF; REM a=-5, b=0 -> 0xFFFFFFFB.
//  cancel at iteration 10 -> busy low next cycle, no done, d unchanged.
//   - Then start DIVU 9/3 -> d=3 after full latency.
//  start held high across the whole operation -> exactly one launch per IDLE cycle; back-to-back ops, each done pulse 1 cycle wide.
//  rstn low mid-RUN -> busy=0, done=0, d=0 immediately (async).
//   - Randomised 10k op/a/b vs reference model at BITS_PER_CYCLE=1 and 2.

Source files
------------

// File: rtl/tinyqv_divider_if.sv
// Handshake and data bundle between the core and the multi-cycle divide unit.
// The core drives the request side (master); the divider answers (slave).
interface tinyqv_divider_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] d;

    modport master (output start, op, a, b, cancel, input busy, done, d);
    modport slave  (input start, op, a, b, cancel, output busy, done, d);
endinterface

// File: rtl/tinyqv_divider.sv
// RV32M DIV/DIVU/REM/REMU unit: restoring shift-subtract on operand magnitudes,
// BITS_PER_CYCLE quotient bits per clock, sign fix-up in one final cycle.
module tinyqv_divider #(
    parameter int BITS_PER_CYCLE = 1  // 1 or 2
) (
    input  logic             clk,
    input  logic             rstn,
    tinyqv_divider_if.slave  bus
);
    localparam int N_ITER = 32 / BITS_PER_CYCLE;
    localparam int CNT_W  = $clog2(N_ITER);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

    state_t           state_q;
    logic [1:0]       op_q;
    logic [31:0]      quo_q;   // unconsumed dividend bits above, quotient bits shift in at the LSB
    logic [31:0]      dvsr_q;
    logic [32:0]      rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_q_q, neg_r_q, div0_q, busy_q, done_q;
    logic [31:0]      d_q;

    logic        is_signed;
    logic [31:0] a_mag, b_mag;
    logic [32:0] rem_d, diff;
    logic [31:0] quo_d;
    logic [31:0] result, fixed;
    logic        negate;

    assign is_signed = ~bus.op[0];
    assign a_mag     = (is_signed && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
    assign b_mag     = (is_signed && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        diff  = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            rem_d = {rem_d[31:0], quo_d[31]};
            quo_d = {quo_d[30:0], 1'b0};
            diff  = rem_d - {1'b0, dvsr_q};
            if (!diff[32]) begin
                rem_d    = diff;
                quo_d[0] = 1'b1;
            end
        end
    end

    // A zero divisor already leaves |a| in the remainder; only the quotient needs forcing.
    assign result = op_q[1] ? rem_q[31:0] : (div0_q ? 32'hFFFF_FFFF : quo_q);
    assign negate = op_q[1] ? neg_r_q : neg_q_q;
    assign fixed  = negate ? (~result + 32'd1) : result;

    // NOTE: sequential state uses non-blocking assignments only; every register,
    // datapath included, is cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            op_q    <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            div0_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.cancel) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            op_q    <= bus.op;
                            quo_q   <= a_mag;
                            dvsr_q  <= b_mag;
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            neg_q_q <= is_signed & (bus.a[31] ^ bus.b[31]) & (bus.b != 32'd0);
                            neg_r_q <= is_signed & bus.a[31];
                            div0_q  <= (bus.b == 32'd0);
                        end
                    end
                    RUN: begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(N_ITER - 1)) state_q <= FIX;
                    end
                    FIX: begin
                        d_q     <= fixed;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.d    = d_q;
endmodule
